sfifo_param: RTL
================

# sfifo_param

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky error flags with explicit clear, and a compile-time first-word-fall-through read mode. It sits between producer and consumer blocks in the same clock domain. It is the default buffering element for new datapath blocks.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 16, number of entries (>=2, any integer)
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- res_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wdata  in  WIDTH  write data
- rd_en  in  1  read request (acknowledge in FWFT mode)
- err_clr  in  1  clears overflow/underflow
- rdata  out  WIDTH  read data
- rvalid  out  1  rdata valid
- count  out  CW  current occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1  status flags
- overflow, underflow  out  1  sticky error flags

## Operation
- Write accepted = wr_en && (!full || read accepted same cycle). Accepted write stores wdata at wr_ptr and advances wr_ptr.
- Read accepted = rd_en && !empty. An accepted read advances rd_ptr.
- Pointers run 0..DEPTH-1. From DEPTH-1 they wrap to 0; no power-of-two assumption.
- count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags are registered and derived from the next count: full = (DEPTH), empty = (0), almost_full = (>= AFULL_TH), almost_empty = (<= AEMPTY_TH).
- wr_en while full with no accepted read: write dropped, memory/pointers unchanged, overflow set.
- rd_en while empty: no pointer change, underflow set. A simultaneous write is still accepted.
- Full + wr_en + rd_en: both accepted, count stays DEPTH, no overflow.
- overflow/underflow stay at 1 until a cycle with err_clr=1. If err_clr coincides with a new error event, the flag stays 1.
- Memory contents are not reset. Only control state is reset.

## Timing
- Asynchronous reset on res_n=0, effective immediately, also mid-operation. Pointers, count, rdata, rvalid, full, almost_full, overflow and underflow go to 0. empty and almost_empty go to 1. Release is synchronous to the next clk edge.
- Default (registered) read: rdata is loaded from mem[rd_ptr] on the edge that accepts the read. rvalid=1 for exactly that following cycle. rdata holds its last value otherwise. Read latency is 1 cycle.
- Status flags and count update on the edge that accepts the operation, so they are visible the cycle after.
- Write-to-read: data written at edge N can be read at edge N+1 (empty deasserts after N).

## Configuration
- SFIFO_FWFT_EN defined: first-word-fall-through mode.
  - rdata = mem[rd_ptr] combinationally and rvalid = !empty.
  - rd_en acts as the acknowledge that pops the head. Head data appears the cycle after the write that made the FIFO non-empty.
- SFIFO_FWFT_EN undefined: registered read mode as described in Timing.
- Flags, count and errors are identical in both modes.

## Test plan
- Reset mid-stream: write 5 words, pull res_n low between edges -> count=0, empty=1, almost_empty=1, rvalid=0 immediately, without waiting for a clock edge. A subsequent read sets underflow=1.
- DEPTH=12, WIDTH=8: write 0x01..0x0C -> full=1, count=12. Read all 12 -> data 0x01..0x0C in order with wrap. Repeat the fill/drain 3 times to exercise pointer wrap at 11->0.
- Overflow: fill DEPTH=16, write 0xAA -> overflow=1, count=16, 0xAA is never read. err_clr=1 for one cycle -> overflow=0. err_clr coinciding with another overflowing write -> overflow stays 1.
- Simultaneous ops:
  - When full, wr_en+rd_en for 4 cycles -> count stays 16, overflow=0, FIFO order preserved.
  - When empty, wr_en+rd_en -> underflow=1, count=1.
- Thresholds with AFULL_TH=14, AEMPTY_TH=2:
  - almost_full rises the cycle after the 14th write and falls after count drops to 13.
  - almost_empty is 1 at count 2 and 0 at count 3.
- Read latency: default build, write 0x5A then read -> rdata=0x5A with rvalid=1 one cycle after the rd_en edge. With SFIFO_FWFT_EN, 0x5A is visible with rvalid=1 the cycle after the write, before any rd_en.

Source files
------------

// File: rtl/sfifo_param.sv
// sfifo_param: single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags. Define SFIFO_FWFT_EN for first-word-fall-through reads.
module sfifo_param #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 16,
   parameter int AFULL_TH    = DEPTH - 2,
   parameter int AEMPTY_TH   = 2,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_en,
   input  logic             err_clr,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_TH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          aFull_q, aFull_d;
   logic          aEmpty_q, aEmpty_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          wrAcc;
   logic          rdAcc;
   logic          ovfEvent;
   logic          udfEvent;

   // Pointers wrap explicitly at DEPTH-1 so any depth works, not just powers of two.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   always_comb begin
      rdAcc    = rd_en && !empty_q;
      wrAcc    = wr_en && (!full_q || rdAcc);
      ovfEvent = wr_en && full_q && !rdAcc;
      udfEvent = rd_en && empty_q;

      wrPtr_d = wrAcc ? nextPtr(wrPtr_q) : wrPtr_q;
      rdPtr_d = rdAcc ? nextPtr(rdPtr_q) : rdPtr_q;

      count_d = count_q;
      unique case ({wrAcc, rdAcc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      full_d   = (count_d == DEPTH_CNT);
      empty_d  = (count_d == '0);
      aFull_d  = (count_d >= AFULL_CNT);
      aEmpty_d = (count_d <= AEMPTY_CNT);

      // A new error event wins over a coincident clear.
      overflow_d  = ovfEvent || (overflow_q && !err_clr);
      underflow_d = udfEvent || (underflow_q && !err_clr);
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         aFull_q     <= 1'b0;
         aEmpty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         aFull_q     <= aFull_d;
         aEmpty_q    <= aEmpty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; only the control state above is initialised.
   always_ff @(posedge clk) begin
      if (wrAcc) begin
         mem[wrPtr_q] <= wdata;
      end
   end

`ifdef SFIFO_FWFT_EN
   assign rdata  = mem[rdPtr_q];
   assign rvalid = !empty_q;
`else
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;

   always_comb begin
      rdata_d  = rdAcc ? mem[rdPtr_q] : rdata_q;
      rvalid_d = rdAcc;
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
`endif

   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = aFull_q;
   assign almost_empty = aEmpty_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule
